idu: RTL and testbench

//   Instruction decode stage directly downstream of the fetch unit. Accepts one 32-bit RV32I

---
 rtl/idu.sv | 123 ++++++++++++
 tb/tb_idu.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/idu.sv
// rtl/idu.sv - RV32I decode stage: one-entry skid-free pipeline register with combinational field/immediate decode
module idu #(
    parameter int XLEN   = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_pre_i,
    output logic              ready_pre_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic              valid_post_o,
    input  logic              ready_post_i,
    input  logic              flush_i,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [2:0]        type_o,
    output logic              wen_o,
    output logic              illegal_o
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                           T_U = 3'd4, T_J = 3'd5, T_ILL = 3'd7;

    state_t            state, state_next;
    logic [INST_W-1:0] inst_q;
    logic [XLEN-1:0]   pc_q;
    logic              accept;
    logic [31:0]       imm32;
    logic [2:0]        typ;

    assign ready_pre_o  = !rst && (state == EMPTY || ready_post_i);
    assign accept       = valid_pre_i && ready_pre_o;
    assign valid_post_o = (state == FULL);
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush_i)
            state_next = EMPTY;
        else if (accept)
            state_next = FULL;
        else if (state == FULL && ready_post_i)
            state_next = EMPTY;
    end

    // A flushed accept never loads, so the discarded word cannot leak into inst_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q <= '0;
            pc_q   <= '0;
        end else if (accept && !flush_i) begin
            inst_q <= inst_i;
            pc_q   <= pc_i;
        end
    end

    always_comb begin
        typ = T_ILL;
        case (inst_q[6:0])
            7'b0110011:                                     typ = T_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: typ = T_I;
            7'b0100011:                                     typ = T_S;
            7'b1100011:                                     typ = T_B;
            7'b0110111, 7'b0010111:                         typ = T_U;
            7'b1101111:                                     typ = T_J;
            default:                                        typ = T_ILL;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (typ)
            T_I: imm32 = {{20{inst_q[31]}}, inst_q[31:20]};
            T_S: imm32 = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
            T_B: imm32 = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
            T_U: imm32 = {inst_q[31:12], 12'b0};
            T_J: imm32 = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Decoded fields read as zero while empty so the idle bus is all-zero after reset.
    always_comb begin
        opcode_o  = '0;
        funct3_o  = '0;
        funct7_o  = '0;
        rs1_o     = '0;
        rs2_o     = '0;
        rd_o      = '0;
        imm_o     = '0;
        type_o    = '0;
        wen_o     = 1'b0;
        illegal_o = 1'b0;
        if (state == FULL) begin
            opcode_o  = inst_q[6:0];
            funct3_o  = inst_q[14:12];
            funct7_o  = inst_q[31:25];
            rs1_o     = (typ == T_U || typ == T_J) ? 5'd0 : inst_q[19:15];
            rs2_o     = (typ == T_I || typ == T_U || typ == T_J) ? 5'd0 : inst_q[24:20];
            rd_o      = (typ == T_S || typ == T_B) ? 5'd0 : inst_q[11:7];
            imm_o     = XLEN'($signed(imm32));
            type_o    = typ;
            illegal_o = (typ == T_ILL);
            wen_o     = (typ == T_R || typ == T_I || typ == T_U || typ == T_J)
                        && (inst_q[11:7] != 5'd0);
        end
    end
endmodule

// File: tb/tb_idu.sv
// tb/tb_idu.sv - directed vector table plus stall, flush and reset sequences for idu
module tb_idu;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_pre_i, ready_pre_o;
    logic [31:0] inst_i, pc_i;
    logic        valid_post_o, ready_post_i, flush_i;
    logic [31:0] inst_o, pc_o, imm_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [2:0]  funct3_o, type_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic        wen_o, illegal_o;

    int checks = 0;
    int failures = 0;

    idu #(.XLEN(32), .INST_W(32)) dut (
        .clk(clk), .rst(rst),
        .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
        .inst_i(inst_i), .pc_i(pc_i),
        .valid_post_o(valid_post_o), .ready_post_i(ready_post_i), .flush_i(flush_i),
        .inst_o(inst_o), .pc_o(pc_o), .opcode_o(opcode_o), .funct3_o(funct3_o),
        .funct7_o(funct7_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .imm_o(imm_o), .type_o(type_o), .wen_o(wen_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        wen;
        logic        ill;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [31:0] stream[4];
    logic [31:0] held;
    int sent, recv;
    logic take, deliver;

    initial begin
        vecs[0] = '{32'hFFF10093, 32'h100, 3'd1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[1] = '{32'hFE208EE3, 32'h104, 3'd3, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b0};
        vecs[2] = '{32'h0020A423, 32'h108, 3'd2, 5'd0, 5'd1, 5'd2, 32'h00000008, 1'b0, 1'b0};
        vecs[3] = '{32'h123452B7, 32'h10C, 3'd4, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 1'b0};
        vecs[4] = '{32'h0000000B, 32'h110, 3'd7, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1};
        vecs[5] = '{32'h008000EF, 32'h114, 3'd5, 5'd1, 5'd0, 5'd0, 32'h00000008, 1'b1, 1'b0};
        vecs[6] = '{32'h002081B3, 32'h118, 3'd0, 5'd3, 5'd1, 5'd2, 32'h00000000, 1'b1, 1'b0};
        vecs[7] = '{32'h00000013, 32'h11C, 3'd1, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0};
        stream[0] = 32'h00100093; stream[1] = 32'h00200113;
        stream[2] = 32'h00300193; stream[3] = 32'h00400213;

        rst = 1'b1; valid_pre_i = 1'b0; inst_i = '0; pc_i = '0;
        ready_post_i = 1'b1; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("ready_pre_in_reset", 32'(ready_pre_o), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1;
        check("reset_valid_post", 32'(valid_post_o), 32'd0);
        check("reset_ready_pre", 32'(ready_pre_o), 32'd1);
        check("reset_inst_o", inst_o, 32'd0);
        check("reset_pc_o", pc_o, 32'd0);
        check("reset_imm_o", imm_o, 32'd0);
        check("reset_type_o", 32'(type_o), 32'd0);
        check("reset_illegal_o", 32'(illegal_o), 32'd0);
        check("reset_wen_o", 32'(wen_o), 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            valid_pre_i = 1'b1; inst_i = vecs[i].inst; pc_i = vecs[i].pc;
            @(posedge clk);
            #1 valid_pre_i = 1'b0;
            check($sformatf("v%0d_valid", i), 32'(valid_post_o), 32'd1);
            check($sformatf("v%0d_inst", i), inst_o, vecs[i].inst);
            check($sformatf("v%0d_pc", i), pc_o, vecs[i].pc);
            check($sformatf("v%0d_type", i), 32'(type_o), 32'(vecs[i].typ));
            check($sformatf("v%0d_rd", i), 32'(rd_o), 32'(vecs[i].rd));
            check($sformatf("v%0d_rs1", i), 32'(rs1_o), 32'(vecs[i].rs1));
            check($sformatf("v%0d_rs2", i), 32'(rs2_o), 32'(vecs[i].rs2));
            check($sformatf("v%0d_imm", i), imm_o, vecs[i].imm);
            check($sformatf("v%0d_wen", i), 32'(wen_o), 32'(vecs[i].wen));
            check($sformatf("v%0d_illegal", i), 32'(illegal_o), 32'(vecs[i].ill));
        end
        @(posedge clk);
        #1 check("drain_to_empty", 32'(valid_post_o), 32'd0);

        // Four back-to-back instructions, consumer stalls on cycles 2..4.
        sent = 0; recv = 0; held = '0;
        for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
            @(negedge clk);
            ready_post_i = !(cyc >= 2 && cyc <= 4);
            valid_pre_i  = (sent < 4);
            inst_i       = (sent < 4) ? stream[sent] : 32'd0;
            pc_i         = 32'h200 + 32'(sent) * 4;
            #1;
            take    = valid_pre_i && ready_pre_o;
            deliver = valid_post_o && ready_post_i;
            if (valid_post_o && !ready_post_i) begin
                check($sformatf("stall_ready_pre_c%0d", cyc), 32'(ready_pre_o), 32'd0);
                if (cyc > 2) check($sformatf("stall_stable_c%0d", cyc), inst_o, held);
                held = inst_o;
            end
            if (deliver) begin
                check($sformatf("stream_order_%0d", recv), inst_o, stream[recv]);
                recv++;
            end
            @(posedge clk);
            if (take) sent++;
        end
        check("stream_all_received", 32'(recv), 32'd4);
        @(negedge clk) valid_pre_i = 1'b0; ready_post_i = 1'b1;
        @(posedge clk);
        #1 check("stream_no_duplicate", 32'(valid_post_o), 32'd0);

        // Flush while full with a simultaneous incoming instruction.
        @(negedge clk);
        valid_pre_i = 1'b1; inst_i = 32'hFFF10093; pc_i = 32'h300; ready_post_i = 1'b0;
        @(posedge clk);
        #1 check("flush_pre_full", 32'(valid_post_o), 32'd1);
        @(negedge clk);
        inst_i = 32'h123452B7; pc_i = 32'h304; ready_post_i = 1'b1; flush_i = 1'b1;
        @(posedge clk);
        #1 check("flush_valid_post", 32'(valid_post_o), 32'd0);
        @(negedge clk) valid_pre_i = 1'b0; flush_i = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1 check("flush_no_ghost", 32'(valid_post_o), 32'd0);
        end

        // Reset while full and stalled drops the held entry.
        @(negedge clk);
        valid_pre_i = 1'b1; inst_i = 32'h0020A423; ready_post_i = 1'b0;
        @(posedge clk);
        #1 check("rst_mid_full", 32'(valid_post_o), 32'd1);
        @(negedge clk) valid_pre_i = 1'b0; rst = 1'b1;
        #1 check("rst_mid_ready_pre", 32'(ready_pre_o), 32'd0);
        @(posedge clk);
        #1 check("rst_mid_empty", 32'(valid_post_o), 32'd0);
        @(negedge clk) rst = 1'b0; ready_post_i = 1'b1;
        #1 check("rst_mid_ready_after", 32'(ready_pre_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
